// File: rtl/corelet_ctrl_if.sv
// Handshake and bus signals between the host and the corelet sequencer.
// master: host side (issues start/config, reports OFIFO status).
// slave : corelet_ctrl side (drives inst word, SRAM read port, status).
interface corelet_ctrl_if #(
   parameter int addr_w = 11,
   parameter int len_w  = 8
);
   logic              start;
   logic              mode;
   logic [len_w-1:0]  n_act;
   logic [3:0]        n_kij;
   logic              ofifo_valid;
   logic [34:0]       inst;
   logic              xmem_rd;
   logic [addr_w-1:0] xmem_addr;
   logic [3:0]        kij;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, mode, n_act, n_kij, ofifo_valid,
      input  inst, xmem_rd, xmem_addr, kij, busy, done, err
   );

   modport slave (
      input  start, mode, n_act, n_kij, ofifo_valid,
      output inst, xmem_rd, xmem_addr, kij, busy, done, err
   );
endinterface

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequences the 35-bit corelet instruction word through
// load / execute / drain / readout phases for every kernel position of a
// convolution tile, fetching weights and activations from the input SRAM.
// Optional feature macro: CORELET_CTRL_OS_EN (output-stationary mode).
// Without it, mode is forced to WS and inst[4]/inst[34] stay 0.
// Every output is registered from the current state, so outputs trail the
// state register by one cycle; the SRAM write strobes trail xmem_rd by one
// more cycle to cover the SRAM read latency.
module corelet_ctrl #(
   parameter int row      = 8,
   parameter int col      = 8,
   parameter int addr_w   = 11,
   parameter int len_w    = 8,
   parameter int l0_depth = 64,
   parameter int w_base   = 1024
) (
   input logic           clk,
   input logic           reset,
   corelet_ctrl_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE,
      KLOAD,
      KPUSH,
      KGAP,
      ALOAD,
      EXEC,
      DRAIN,
      OREAD,
      NEXT,
      DONE
   } state_t;

   localparam logic [len_w-1:0]  ROW_N    = len_w'(row);
   localparam logic [len_w-1:0]  COL_N    = len_w'(col);
   localparam logic [len_w-1:0]  L0_N     = len_w'(l0_depth);
   localparam logic [addr_w-1:0] W_BASE_A = addr_w'(w_base);
   localparam logic [addr_w-1:0] COL_A    = addr_w'(col);
`ifdef CORELET_CTRL_OS_EN
   localparam logic [len_w-1:0]  RC_N     = len_w'(row + col);
`endif

   state_t            r_state;
   logic [len_w-1:0]  r_cnt;
   logic [len_w-1:0]  r_n_act;
   logic [3:0]        r_n_kij;
   logic [3:0]        r_pass;
   logic [34:0]       r_inst;
   logic              r_xmem_rd;
   logic [addr_w-1:0] r_xmem_addr;
   logic [3:0]        r_kij;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
`ifdef CORELET_CTRL_OS_EN
   logic              r_mode;
   logic              r_rd_os;
`endif

   logic              w_os;
   logic              w_start_ok;
   logic [addr_w-1:0] w_waddr;

`ifdef CORELET_CTRL_OS_EN
   assign w_os = r_mode;
`else
   assign w_os = 1'b0;
`endif

   assign w_start_ok = (bus.n_act != '0) && (bus.n_act <= L0_N) && (bus.n_kij != '0);
   assign w_waddr    = W_BASE_A + (addr_w'(r_pass) * COL_A) + addr_w'(r_cnt);

   assign bus.inst      = r_inst;
   assign bus.xmem_rd   = r_xmem_rd;
   assign bus.xmem_addr = r_xmem_addr;
   assign bus.kij       = r_kij;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.err       = r_err;

   // Tile sequencer: state/counter update plus registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_n_act     <= '0;
         r_n_kij     <= '0;
         r_pass      <= '0;
         r_inst      <= '0;
         r_xmem_rd   <= 1'b0;
         r_xmem_addr <= '0;
         r_kij       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
`ifdef CORELET_CTRL_OS_EN
         r_mode      <= 1'b0;
         r_rd_os     <= 1'b0;
`endif
      end else begin
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_xmem_rd  <= 1'b0;
         r_inst     <= '0;
         // Delayed strobes: SFP accumulates the word read out one cycle earlier,
         // and the SRAM data of the previous read is written one cycle later.
         r_inst[33] <= r_inst[6];
`ifdef CORELET_CTRL_OS_EN
         r_inst[2]  <= r_xmem_rd & ~r_rd_os;
         r_inst[4]  <= r_xmem_rd & r_rd_os;
         r_inst[34] <= (r_state != IDLE) & r_mode;
         r_rd_os    <= 1'b0;
`else
         r_inst[2]  <= r_xmem_rd;
`endif
         r_busy     <= (r_state != IDLE);
         r_kij      <= r_pass;

         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  if (w_start_ok) begin
                     r_n_act <= bus.n_act;
                     r_n_kij <= bus.n_kij;
`ifdef CORELET_CTRL_OS_EN
                     r_mode  <= bus.mode;
`endif
                     r_pass  <= '0;
                     r_cnt   <= '0;
                     r_state <= KLOAD;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end

            // row weight reads, then one flush cycle for the delayed strobe.
            KLOAD: begin
               if (r_cnt < ROW_N) begin
                  r_xmem_rd   <= 1'b1;
                  r_xmem_addr <= w_waddr;
`ifdef CORELET_CTRL_OS_EN
                  r_rd_os     <= w_os;
`endif
                  r_cnt       <= r_cnt + 1'b1;
               end else begin
                  r_cnt   <= '0;
                  r_state <= w_os ? ALOAD : KPUSH;
               end
            end

            KPUSH: begin
               r_inst[3] <= 1'b1;
               r_inst[0] <= 1'b1;
               if (r_cnt == COL_N - 1'b1) begin
                  r_cnt   <= '0;
                  r_state <= KGAP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            KGAP: begin
               if (r_cnt == COL_N - 1'b1) begin
                  r_cnt   <= '0;
                  r_state <= ALOAD;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            // n_act activation reads, then one flush cycle.
            ALOAD: begin
               if (r_cnt < r_n_act) begin
                  r_xmem_rd   <= 1'b1;
                  r_xmem_addr <= addr_w'(r_cnt);
                  r_cnt       <= r_cnt + 1'b1;
               end else begin
                  r_cnt   <= '0;
                  r_state <= EXEC;
               end
            end

            EXEC: begin
               r_inst[3] <= 1'b1;
               r_inst[1] <= 1'b1;
               if (r_cnt == r_n_act - 1'b1) begin
                  r_cnt   <= '0;
                  r_state <= DRAIN;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            DRAIN: begin
`ifdef CORELET_CTRL_OS_EN
               if (w_os) begin
                  if (r_cnt == RC_N - 1'b1) begin
                     r_cnt   <= '0;
                     r_state <= NEXT;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end else if (bus.ofifo_valid) begin
                  r_cnt   <= '0;
                  r_state <= OREAD;
               end
`else
               if (bus.ofifo_valid) begin
                  r_cnt   <= '0;
                  r_state <= OREAD;
               end
`endif
            end

            // n_act OFIFO reads, then one cycle for the trailing accumulate.
            OREAD: begin
               if (r_cnt < r_n_act) begin
                  r_inst[6] <= 1'b1;
                  r_cnt     <= r_cnt + 1'b1;
               end else begin
                  r_cnt   <= '0;
                  r_state <= NEXT;
               end
            end

            NEXT: begin
               r_pass <= r_pass + 1'b1;
               if (r_pass == r_n_kij - 1'b1) begin
                  r_state <= DONE;
               end else begin
                  r_state <= KLOAD;
               end
            end

            DONE: begin
               r_done  <= 1'b1;
               r_state <= IDLE;
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
